dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words in the data memory; word index = req_addr[31:2].
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder accepts a request this cycle.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_access  input  4  [3]=1 store, 0 load; [2] sign flag, ignored here; [1:0] size: 00=1B, 01=2B, 10=4B, 11=illegal.
REQ-008 req_wdata  input  32  store data, unaligned, LSB-justified.
REQ-009 resp_valid  output  1  response available.
REQ-010 resp_ready  input  1  initiator takes the response.
REQ-011 resp_rdata  output  32  raw aligned memory word; lane extraction and sign extension stay on the initiator side.
REQ-012 resp_err  output  1  request rejected: misaligned, illegal size or out of range.
REQ-013 err_cnt  output  8  saturating count of error responses.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Accept on req_valid&&req_ready; capture addr, access and wdata into request registers; IDLE->ACCESS.
REQ-016 ACCESS: perform the memory operation on the next edge; ACCESS->RESP unconditionally.
REQ-017 RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_valid&&resp_ready, then RESP->IDLE.
REQ-018 Latency: resp_valid rises after the 2nd rising edge following the accept edge, for loads, stores and errors alike; minimum interval between accepts is 3 cycles.
REQ-019 Error conditions: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0; addr[31:2]>=DEPTH_WORDS.
REQ-020 An errored request SHALL NOT modify memory, and SHALL return resp_err=1 and resp_rdata=0.
REQ-021 Load: resp_rdata=mem[addr[31:2]] (full word); resp_err=0.
REQ-022 Store byte enables: 1B -> be=1<<addr[1:0], lane data={4{wdata[7:0]}}; 2B -> be=0011 (addr[1]=0) or 1100 (addr[1]=1), lane data={2{wdata[15:0]}}; 4B -> be=1111, data=wdata.
REQ-023 Store: only enabled byte lanes written; other lanes preserved; resp_rdata=0, resp_err=0.
REQ-024 err_cnt increments by 1 on each error response handshake; saturates at 255, no wrap.
REQ-025 req_valid while not in IDLE: ignored and not captured; the initiator holds it.
REQ-026 resp_ready asserted outside RESP: no effect.

Reset
REQ-027 rstn low: state=IDLE, req_ready=1 once released, resp_valid=0, resp_rdata=0, resp_err=0, err_cnt=0, request registers=0.
REQ-028 Reset asserted while in ACCESS: the pending write is suppressed; memory unchanged.
REQ-029 Memory contents are not reset; they persist across reset.

Structure
REQ-030 Shared package dmem_pkg holds: access-field constants (ST bit 3, SGN bit 2, SIZE_B=00, SIZE_H=01, SIZE_W=10) and the FSM state enum; the CPU-side load/store alignment logic uses the same constants.
REQ-031 One sub-module, dmem_bank: synchronous single-port RAM, DEPTH_WORDS x 32, 4-bit byte-enable write, registered read; no reset.

Verification
REQ-032 Store 4B 0xDEADBEEF at 0x10, then load 4B at 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each accept.
REQ-033 After REQ-032, store 1B wdata=0x000000AA at 0x13, then load 4B at 0x10 -> 0xAAADBEEF; store 2B 0x1234 at 0x10 -> next load 4B returns 0xAAAD1234.
REQ-034 Load 2B at 0x11, store 4B at 0x12, and access size=11 -> each returns resp_err=1 and resp_rdata=0; memory at 0x10 unchanged; err_cnt=3.
REQ-035 Load 4B at DEPTH_WORDS*4 -> resp_err=1; 256 consecutive error responses -> err_cnt stays at 255.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the handshake.
REQ-037 Assert rstn=0 in ACCESS of a 4B store of 0x55555555 to 0x20 -> outputs go to reset values immediately; a later load at 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-field layout,
// FSM state encoding and the store alignment helpers used on both sides of the bus.
package dmem_pkg;

    localparam int ST_BIT  = 3;
    localparam int SGN_BIT = 2;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  access;
        logic [31:0] wdata;
    } req_t;

    // Illegal size or an address not naturally aligned to the access size.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << addr_lo;
            SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-justified store data onto every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_B:  lanes = {4{wdata[7:0]}};
            SIZE_H:  lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_access;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_access, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_access, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Write the enabled lanes, or register the addressed word when reading.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, runs it against the
// RAM bank and returns the raw aligned word or an error response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_if.slave      bus,
    output logic [7:0] err_cnt
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_e      state_r;
    req_t        req_r;
    logic        req_ready_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic [7:0]  err_cnt_r;

    logic             req_store_s;
    logic             req_err_s;
    logic             bank_en_s;
    logic             bank_we_s;
    logic [IDX_W-1:0] bank_addr_s;
    logic [3:0]       bank_be_s;
    logic [31:0]      bank_wdata_s;
    logic [31:0]      bank_rdata_s;
    logic             unused_sgn_s;

    // The sign flag only matters for the initiator's lane extraction.
    assign unused_sgn_s = req_r.access[SGN_BIT];

    assign req_store_s  = req_r.access[ST_BIT];
    assign bank_be_s    = store_be(req_r.access[1:0], req_r.addr[1:0]);
    assign bank_wdata_s = store_lanes(req_r.access[1:0], req_r.wdata);

    // Error decode of the captured request: alignment/size or beyond the array.
    always_comb begin
        req_err_s = size_err(req_r.access[1:0], req_r.addr[1:0])
                  | ({2'b00, req_r.addr[31:2]} >= DEPTH_L);
    end

    // Bank control: a load's word is fetched on the accept edge from the bus
    // address, so it is already registered when ACCESS captures the response.
    // Stores write on the ACCESS edge; an asynchronous reset drops the state
    // back to IDLE and thereby kills the pending write.
    always_comb begin
        bank_en_s   = 1'b0;
        bank_we_s   = 1'b0;
        bank_addr_s = bus.req_addr[IDX_W+1:2];
        case (state_r)
            S_IDLE: begin
                bank_en_s = bus.req_valid;
            end
            S_ACCESS: begin
                bank_en_s   = req_store_s && !req_err_s;
                bank_we_s   = req_store_s && !req_err_s;
                bank_addr_s = req_r.addr[IDX_W+1:2];
            end
            default: begin
                bank_en_s = 1'b0;
            end
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en_s),
        .we    (bank_we_s),
        .be    (bank_be_s),
        .addr  (bank_addr_s),
        .wdata (bank_wdata_s),
        .rdata (bank_rdata_s)
    );

    // Request/response FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= S_IDLE;
            req_r        <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            err_cnt_r    <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        req_r.addr   <= bus.req_addr;
                        req_r.access <= bus.req_access;
                        req_r.wdata  <= bus.req_wdata;
                        req_ready_r  <= 1'b0;
                        state_r      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= req_err_s;
                    resp_rdata_r <= (req_err_s || req_store_s) ? 32'h0000_0000 : bank_rdata_s;
                    state_r      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        if (resp_err_r && (err_cnt_r != 8'hFF)) begin
                            err_cnt_r <= err_cnt_r + 8'd1;
                        end
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                        req_ready_r  <= 1'b1;
                        state_r      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign err_cnt        = err_cnt_r;

endmodule
